// File: rtl/ctrl_conv_sched.sv
// rtl/ctrl_conv_sched.sv - window sequencer for the 1-D convolution datapath
// Borrows the write-side memory address, runs each K-tap MAC window and presents results.
module ctrl_conv_sched #(
    parameter int N  = 30,
    parameter int K  = 9,
    parameter int AW = 5,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          m_ready,
    output logic          en_ext_ctrl,
    output logic          ext_load_addr,
    output logic [AW-1:0] ext_load_addr_val,
    output logic          ext_incr_addr,
    output logic [CW-1:0] coef_addr,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          m_valid,
    output logic [AW-1:0] out_idx,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] BASE_LAST = AW'(N - K);
    localparam logic [CW-1:0] TAP_LAST  = CW'(K - 1);
    localparam logic [AW:0]   ADDR_END  = (AW + 1)'(N);

    state_t        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [CW-1:0] tap_q, tap_d;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        tap_d   = tap_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    base_d  = '0;
                end
            end
            S_LOAD: begin
                state_d = S_MAC;
                tap_d   = '0;
            end
            S_MAC: begin
                if (tap_q == TAP_LAST) begin
                    state_d = S_OUT;
                    tap_d   = '0;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            S_OUT: begin
                if (m_ready) begin
                    if (base_q == BASE_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        base_d  = base_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                base_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                base_d  = '0;
                tap_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            tap_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            tap_q   <= tap_d;
        end
    end

    // No increment on the last tap keeps mem_addr at base+K-1, inside the memory.
    assign en_ext_ctrl       = (state_q == S_LOAD) || (state_q == S_MAC) || (state_q == S_OUT);
    assign ext_load_addr     = (state_q == S_LOAD);
    assign ext_load_addr_val = (state_q == S_LOAD) ? base_q : '0;
    assign ext_incr_addr     = (state_q == S_MAC) && (tap_q != TAP_LAST);
    assign coef_addr         = (state_q == S_MAC) ? tap_q : '0;
    assign acc_clr           = (state_q == S_LOAD);
    assign acc_en            = (state_q == S_MAC);
    assign m_valid           = (state_q == S_OUT);
    assign out_idx           = (state_q == S_OUT) ? base_q : '0;
    assign done              = (state_q == S_DONE);

    logic [AW:0] mac_addr;
    assign mac_addr = {1'b0, base_q} + (AW + 1)'(tap_q);

    a_addr_cmd_excl: assert property (@(posedge clk) disable iff (reset)
        !(ext_load_addr && ext_incr_addr));
    a_acc_cmd_excl: assert property (@(posedge clk) disable iff (reset)
        !(acc_clr && acc_en));
    a_load_in_range: assert property (@(posedge clk) disable iff (reset)
        {1'b0, ext_load_addr_val} < ADDR_END);
    a_mac_in_range: assert property (@(posedge clk) disable iff (reset)
        !acc_en || (mac_addr < ADDR_END));
    a_idx_in_range: assert property (@(posedge clk) disable iff (reset)
        {1'b0, out_idx} < ADDR_END);

endmodule

// File: tb/tb_ctrl_conv_sched.sv
// tb/tb_ctrl_conv_sched.sv - self-checking bench for ctrl_conv_sched
module tb_ctrl_conv_sched;
    localparam int N  = 30;
    localparam int K  = 9;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, start, m_ready;
    logic          en_ext_ctrl, ext_load_addr, ext_incr_addr, acc_clr, acc_en, m_valid, done;
    logic [AW-1:0] ext_load_addr_val, out_idx;
    logic [CW-1:0] coef_addr;
    logic [20:0]   dut_vec;

    ctrl_conv_sched #(.N(N), .K(K), .AW(AW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .m_ready(m_ready),
        .en_ext_ctrl(en_ext_ctrl), .ext_load_addr(ext_load_addr),
        .ext_load_addr_val(ext_load_addr_val), .ext_incr_addr(ext_incr_addr),
        .coef_addr(coef_addr), .acc_clr(acc_clr), .acc_en(acc_en),
        .m_valid(m_valid), .out_idx(out_idx), .done(done)
    );

    always #5 clk = ~clk;

    assign dut_vec = {en_ext_ctrl, ext_load_addr, ext_load_addr_val, ext_incr_addr, coef_addr,
                      acc_clr, acc_en, m_valid, out_idx, done};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [20:0] pk(input logic en, input logic ld, input logic [4:0] lv,
                                       input logic inc, input logic [3:0] cf, input logic clr,
                                       input logic ae, input logic mv, input logic [4:0] ix,
                                       input logic dn);
        return {en, ld, lv, inc, cf, clr, ae, mv, ix, dn};
    endfunction

    // Memory/accumulator model: mem[i] = i, unit coefficients.
    int m_addr    = 0;
    int acc       = 0;
    int next_idx  = 0;
    int out_total = 0;
    int done_total = 0;
    int last_idx  = -1;

    always @(posedge clk) begin
        if (reset) begin
            next_idx = 0;
        end else begin
            chk("ld_incr_excl", int'(ext_load_addr & ext_incr_addr), 0);
            chk("clr_en_excl", int'(acc_clr & acc_en), 0);
            chk("addr_range", int'((ext_load_addr && int'(ext_load_addr_val) >= N) ||
                                   (acc_en && m_addr >= N) ||
                                   (m_valid && int'(out_idx) >= N)), 0);
            if (done) begin
                done_total++;
                next_idx = 0;
                chk("en_low_at_done", int'(en_ext_ctrl), 0);
            end
            if (m_valid && m_ready) begin
                chk("out_value", acc, 9 * int'(out_idx) + 36);
                chk("out_order", int'(out_idx), next_idx);
                last_idx = int'(out_idx);
                next_idx++;
                out_total++;
            end
            if (acc_en) acc += (m_addr < N) ? m_addr : 0;
            if (acc_clr) acc = 0;
            if (en_ext_ctrl && ext_load_addr) m_addr = int'(ext_load_addr_val);
            else if (en_ext_ctrl && ext_incr_addr) m_addr++;
        end
    end

    typedef struct {
        logic        start;
        logic        rdy;
        logic [20:0] exp;
    } vec_t;
    vec_t tbl[13];

    task automatic run_full(input int bp_idx, input bit perturb, output int cycles);
        bit bp_done;
        bp_done = 1'b0;
        start   = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        while (!done && cycles < 2000) begin
            start = perturb && ((acc_en && coef_addr == 4'd2) || (m_valid && out_idx == 5'd5));
            if (bp_idx >= 0 && !bp_done && m_valid && int'(out_idx) == bp_idx) begin
                m_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    chk("bp_valid", int'(m_valid), 1);
                    chk("bp_idx", int'(out_idx), bp_idx);
                    chk("bp_no_load", int'(ext_load_addr), 0);
                    @(negedge clk);
                    cycles++;
                end
                m_ready = 1'b1;
                bp_done = 1'b1;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        chk("run_reached_done", int'(done), 1);
    endtask

    int cyc, o0, d0, n;

    initial begin
        tbl[0] = '{1'b1, 1'b1, 21'd0};
        tbl[1] = '{1'b0, 1'b1, pk(1'b1, 1'b1, 5'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0)};
        for (int t = 0; t < K; t++)
            tbl[2+t] = '{1'b0, 1'b1, pk(1'b1, 1'b0, 5'd0, (t < K - 1), 4'(t), 1'b0, 1'b1,
                                        1'b0, 5'd0, 1'b0)};
        tbl[11] = '{1'b0, 1'b1, pk(1'b1, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0)};
        tbl[12] = '{1'b0, 1'b1, pk(1'b1, 1'b1, 5'd1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0)};

        reset = 1'b1; start = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'(dut_vec), 0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            chk($sformatf("vec%0d", i), int'(dut_vec), int'(tbl[i].exp));
            start   = tbl[i].start;
            m_ready = tbl[i].rdy;
            @(negedge clk);
        end
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("reset_mid_load", int'(dut_vec), 0);
        reset = 1'b0;

        o0 = out_total; d0 = done_total;
        run_full(-1, 1'b0, cyc);
        chk("full_cycles", cyc, 243);
        chk("full_outputs", out_total - o0, 22);
        chk("last_idx", last_idx, 21);
        @(negedge clk);
        chk("idle_after_done", int'(dut_vec), 0);
        chk("done_once", done_total - d0, 1);

        o0 = out_total;
        run_full(3, 1'b0, cyc);
        chk("bp_cycles", cyc, 248);
        chk("bp_outputs", out_total - o0, 22);
        @(negedge clk);

        o0 = out_total;
        run_full(-1, 1'b1, cyc);
        chk("perturb_cycles", cyc, 243);
        chk("perturb_outputs", out_total - o0, 22);
        @(negedge clk);

        o0 = out_total; d0 = done_total;
        run_full(-1, 1'b0, cyc);
        chk("rerun_cycles", cyc, 243);
        chk("rerun_outputs", out_total - o0, 22);
        @(negedge clk);
        chk("rerun_done_once", done_total - d0, 1);

        start = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(acc_en && coef_addr == 4'd4) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reached_tap4", int'(acc_en && coef_addr == 4'd4), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_mac", int'(dut_vec), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", int'(dut_vec), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_load", int'(dut_vec),
            int'(pk(1'b1, 1'b1, 5'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0)));
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("restart_done", int'(done), 1);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ctrl_conv_sched.md
Name: ctrl_conv_sched

Overview:
- Sequencer for the 1-D convolution datapath.
- After the input memory (N words) is filled by the write-side controller, it takes over the memory address through that controller's external-control inputs.
- It sweeps every valid K-tap window, drives the coefficient address and accumulator enables, and presents each finished output through a valid/ready handshake.
- It returns address control to the write side when all N-K+1 outputs are delivered.

Parameters:
- N, 30, input memory depth (words); addresses 0..N-1.
- K, 9, filter taps; 1 <= K <= N.
- AW, 5, memory address width; requires 2^AW >= N.
- CW, 4, coefficient address width; requires 2^CW >= K.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  memory full, begin convolution; sampled only in IDLE
- m_ready  in  1  downstream accepts current output
- en_ext_ctrl  out  1  hands memory address control to this block
- ext_load_addr  out  1  one-cycle load of ext_load_addr_val into mem_addr
- ext_load_addr_val  out  AW  window base address
- ext_incr_addr  out  1  mem_addr increment request
- coef_addr  out  CW  coefficient index for the current tap
- acc_clr  out  1  clear accumulator
- acc_en  out  1  accumulate mem_data*coef this cycle
- m_valid  out  1  accumulator holds a completed output
- out_idx  out  AW  index of the output currently presented (equals base)
- done  out  1  one-cycle pulse after the last output handshake

Behaviour:
- Registers: state, base (AW bits), tap (CW bits).
- All outputs are combinational decodes of the registers (Moore).
- Address timing: mem_addr updates the cycle after ext_load_addr or ext_incr_addr; memory data is valid in the same cycle as mem_addr.
- Reset (any cycle, including mid-operation):
  - state=IDLE, base=0, tap=0.
  - All outputs 0; ext_load_addr_val=0, coef_addr=0, out_idx=0.
- IDLE:
  - All outputs 0.
  - start=1 moves to LOAD with base=0.
- LOAD (1 cycle):
  - en_ext_ctrl=1, ext_load_addr=1, ext_load_addr_val=base, acc_clr=1.
  - Next state MAC with tap=0.
- MAC (exactly K cycles):
  - en_ext_ctrl=1, acc_en=1, coef_addr=tap.
  - ext_incr_addr=1 when tap<K-1, otherwise 0, so mem_addr never exceeds base+K-1 <= N-1.
  - While tap<K-1: tap increments.
  - At tap=K-1: next state OUT, tap cleared to 0.
- OUT:
  - en_ext_ctrl=1, m_valid=1, out_idx=base. Hold indefinitely while m_ready=0.
  - Handshake on m_valid & m_ready:
    - base<N-K: base increments, next state LOAD.
    - base=N-K: next state DONE.
- DONE (1 cycle):
  - done=1, en_ext_ctrl=0.
  - Next state IDLE; base cleared to 0.
- start asserted outside IDLE is ignored; it does not restart or queue.
- m_ready outside OUT is ignored.
- Per-output latency with m_ready held 1: K+2 cycles (LOAD + K MAC + OUT).
- Total outputs N-K+1 (default 22). Full run with m_ready=1: (N-K+1)*(K+2)+1 cycles from the LOAD cycle through DONE (default 243).
- Invariants, each checked by an assertion:
  - ext_load_addr and ext_incr_addr are never both 1.
  - acc_clr and acc_en are never both 1.
  - Address outputs never reach N.
- K=N degenerate case: exactly one window (base=0), then DONE.

Test Plan:
- Reset then start pulse, m_ready=1:
  - LOAD with ext_load_addr_val=0.
  - 9 MAC cycles with coef_addr 0..8 and ext_incr_addr high for exactly 8 of them.
  - m_valid on cycle 11 with out_idx=0.
- Full run, m_ready=1, memory preloaded with value i at address i, unit coefficients:
  - 22 outputs; output j equals 9j+36.
  - done pulses exactly once; en_ext_ctrl falls with done.
  - Total 243 cycles.
- Backpressure, m_ready held 0 for 5 cycles at output 3:
  - m_valid and out_idx=3 stable the whole time.
  - No LOAD until the handshake; output value unchanged.
- Final window: out_idx=21 handshake leads to the DONE state and then IDLE.
  - No address at or above 30 is requested in any cycle.
- Reset asserted during MAC at tap=4:
  - Next cycle all outputs 0 and state IDLE.
  - A new start restarts at base=0.
- start pulsed during MAC and OUT:
  - No effect; sequence identical to the unperturbed run.
  - Second start after done begins a fresh 22-output run.
